// File: rtl/seg7_pattern_decoder_pkg.sv
// Shared 7-segment pattern constants, per-digit tracker states and the pattern -> one-hot decode table.
// Pure definitions: no latency and no backpressure.
package seg7_pattern_decoder_pkg;

  localparam int NUM_DIGITS = 2;

  localparam logic [6:0] SEG7_0 = 7'h3f;
  localparam logic [6:0] SEG7_1 = 7'h06;
  localparam logic [6:0] SEG7_2 = 7'h5b;
  localparam logic [6:0] SEG7_3 = 7'h4f;
  localparam logic [6:0] SEG7_4 = 7'h66;
  localparam logic [6:0] SEG7_5 = 7'h6d;
  localparam logic [6:0] SEG7_6 = 7'h7d;
  localparam logic [6:0] SEG7_7 = 7'h07;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_TRACK    = 2'd1,
    ST_LOCKED   = 2'd2
  } digit_state_t;

  typedef struct packed {
    logic [7:0] num;
    logic       invalid;
  } decode_t;

  // Unknown patterns decode to a zero value with the invalid flag set.
  function automatic decode_t seg7_decode(input logic [6:0] pattern);
    decode_t d;
    d.num     = 8'h00;
    d.invalid = 1'b0;
    case (pattern)
      SEG7_0:  d.num = 8'h01;
      SEG7_1:  d.num = 8'h02;
      SEG7_2:  d.num = 8'h04;
      SEG7_3:  d.num = 8'h08;
      SEG7_4:  d.num = 8'h10;
      SEG7_5:  d.num = 8'h20;
      SEG7_6:  d.num = 8'h40;
      SEG7_7:  d.num = 8'h80;
      default: d.invalid = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_digit_tracker.sv
// One digit's stability tracker: locks after STABLE_COUNT equal enabled samples, then decodes.
// Outputs are registered on the locking edge; no backpressure, disabled cycles freeze all state.
module seg7_digit_tracker
  import seg7_pattern_decoder_pkg::*;
#(
  parameter int STABLE_COUNT = 4,
  parameter int CNT_W        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] pattern,
  output logic [7:0] num,
  output logic       invalid,
  output logic       locked,
  output logic       update
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT - 1);

  digit_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [6:0]       last, last_nxt;
  logic             lock_now;
  logic             same;
  decode_t          dec;

  assign same = (pattern == last);
  assign dec  = seg7_decode(pattern);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    lock_now  = 1'b0;
    if (en) begin
      case (state)
        ST_UNLOCKED: begin
          last_nxt = pattern;
          cnt_nxt  = '0;
          if (CNT_MAX == '0) begin
            state_nxt = ST_LOCKED;
            lock_now  = 1'b1;
          end else begin
            state_nxt = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (same) begin
            if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
            if (cnt_nxt == CNT_MAX) begin
              state_nxt = ST_LOCKED;
              lock_now  = 1'b1;
            end
          end else begin
            last_nxt = pattern;
            cnt_nxt  = '0;
          end
        end
        ST_LOCKED: begin
          // Outputs keep the old value while the new pattern proves itself.
          if (!same) begin
            last_nxt  = pattern;
            cnt_nxt   = '0;
            state_nxt = ST_TRACK;
          end
        end
        default: state_nxt = ST_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_UNLOCKED;
      cnt     <= '0;
      last    <= 7'h00;
      num     <= 8'h00;
      invalid <= 1'b0;
      locked  <= 1'b0;
      update  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      last   <= last_nxt;
      locked <= (state_nxt == ST_LOCKED);
      update <= 1'b0;
      if (lock_now) begin
        num     <= dec.num;
        invalid <= dec.invalid;
        update  <= (dec.num != num) || (dec.invalid != invalid);
      end
    end
  end

endmodule

// File: rtl/seg7_pattern_decoder.sv
// Segment-pin readback monitor: recovers the one-hot value of each of two multiplexed digits.
// A digit locks 2*(STABLE_COUNT-1) edges after its new pattern with the cathode toggling; no backpressure.
module seg7_pattern_decoder
  import seg7_pattern_decoder_pkg::*;
#(
  parameter int STABLE_COUNT = 4,
  parameter int CNT_W        = 3
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Segment_A,
  input  logic       i_Segment_B,
  input  logic       i_Segment_C,
  input  logic       i_Segment_D,
  input  logic       i_Segment_E,
  input  logic       i_Segment_F,
  input  logic       i_Segment_G,
  input  logic       i_Digit_Cath,
  output logic [7:0] o_Onehot_Num_0,
  output logic [7:0] o_Onehot_Num_1,
  output logic [1:0] o_Locked,
  output logic [1:0] o_Invalid,
  output logic [1:0] o_Update
);

  logic [6:0] pattern;
  logic [7:0] num [NUM_DIGITS];

  assign pattern = {i_Segment_G, i_Segment_F, i_Segment_E, i_Segment_D,
                    i_Segment_C, i_Segment_B, i_Segment_A};

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    seg7_digit_tracker #(
      .STABLE_COUNT (STABLE_COUNT),
      .CNT_W        (CNT_W)
    ) u_tracker (
      .clk     (i_Clk),
      .rst_n   (i_Rst_n),
      .en      (i_Digit_Cath == 1'(d)),
      .pattern (pattern),
      .num     (num[d]),
      .invalid (o_Invalid[d]),
      .locked  (o_Locked[d]),
      .update  (o_Update[d])
    );
  end

  assign o_Onehot_Num_0 = num[0];
  assign o_Onehot_Num_1 = num[1];

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Directed bench for seg7_pattern_decoder: hand sequences for lock/relock/glitch/reset plus a vector table.
module tb_seg7_pattern_decoder;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg;
  logic       cath;
  logic [7:0] num0, num1;
  logic [1:0] locked, invalid, update;

  int checks = 0;
  int errors = 0;
  int upd0 = 0;
  int upd1 = 0;
  int both = 0;

  seg7_pattern_decoder #(.STABLE_COUNT(4), .CNT_W(3)) dut (
    .i_Clk          (clk),
    .i_Rst_n        (rst_n),
    .i_Segment_A    (seg[0]),
    .i_Segment_B    (seg[1]),
    .i_Segment_C    (seg[2]),
    .i_Segment_D    (seg[3]),
    .i_Segment_E    (seg[4]),
    .i_Segment_F    (seg[5]),
    .i_Segment_G    (seg[6]),
    .i_Digit_Cath   (cath),
    .o_Onehot_Num_0 (num0),
    .o_Onehot_Num_1 (num1),
    .o_Locked       (locked),
    .o_Invalid      (invalid),
    .o_Update       (update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cath;
    logic [6:0] pat;
    int         edges;
    logic [7:0] num0;
    logic [7:0] num1;
    logic [1:0] locked;
    logic [1:0] invalid;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one sample, clock it, then observe 1 time unit after the edge.
  task automatic step(input logic c, input logic [6:0] p);
    cath = c;
    seg  = p;
    @(posedge clk);
    #1;
    if (update[0]) upd0++;
    if (update[1]) upd1++;
    if (&update) both++;
  endtask

  task automatic clr_counts();
    upd0 = 0;
    upd1 = 0;
  endtask

  function automatic logic [6:0] enc(input int i);
    case (i)
      0: return 7'h3f;
      1: return 7'h06;
      2: return 7'h5b;
      3: return 7'h4f;
      4: return 7'h66;
      5: return 7'h6d;
      6: return 7'h7d;
      default: return 7'h07;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    cath  = 1'b0;
    seg   = 7'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {num0, num1, locked, invalid, update}, 32'h0);
    rst_n = 1'b1;

    // Cathode toggling, digit0=3f, digit1=7d.
    clr_counts();
    for (int i = 0; i < 6; i++) step(i[0], i[0] ? 7'h7d : 7'h3f);
    chk("t2_not_locked_yet", locked, 2'b00);
    step(1'b0, 7'h3f);
    chk("t2_lock0", locked, 2'b01);
    chk("t2_num0", num0, 8'h01);
    chk("t2_upd0_pulse", update, 2'b01);
    step(1'b1, 7'h7d);
    chk("t2_lock1", locked, 2'b11);
    chk("t2_num1", num1, 8'h40);
    chk("t2_upd1_pulse", update, 2'b10);
    for (int i = 0; i < 4; i++) step(i[0], i[0] ? 7'h7d : 7'h3f);
    chk("t2_upd0_count", upd0, 1);
    chk("t2_upd1_count", upd1, 1);
    chk("t2_update_idle", update, 2'b00);

    // Digit0 changes 3f -> 5b while digit1 stays on 7d.
    clr_counts();
    step(1'b0, 7'h5b);
    chk("t3_unlock0", locked, 2'b10);
    chk("t3_num0_held", num0, 8'h01);
    for (int i = 0; i < 5; i++) step(~i[0], i[0] ? 7'h5b : 7'h7d);
    chk("t3_still_track", locked, 2'b10);
    chk("t3_num0_still_held", num0, 8'h01);
    step(1'b0, 7'h5b);
    chk("t3_relock", locked, 2'b11);
    chk("t3_num0_new", num0, 8'h04);
    chk("t3_upd_pulse", update, 2'b01);
    step(1'b1, 7'h7d);
    chk("t3_upd0_count", upd0, 1);
    chk("t3_upd1_count", upd1, 0);
    chk("t3_num1_untouched", num1, 8'h40);

    // Back to 3f, then a one-sample glitch to 06 must not produce an update.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 7'h3f);
      step(1'b1, 7'h7d);
    end
    chk("t5_prelock_num0", num0, 8'h01);
    clr_counts();
    step(1'b0, 7'h06);
    step(1'b1, 7'h7d);
    chk("t5_glitch_unlock", locked, 2'b10);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 7'h3f);
      step(1'b1, 7'h7d);
    end
    chk("t5_relocked", locked, 2'b11);
    chk("t5_num0_same", num0, 8'h01);
    chk("t5_no_upd0", upd0, 0);
    chk("t5_no_upd1", upd1, 0);

    // Vector table: held-cathode runs, invalid patterns, all eight table entries.
    tbl[0] = '{1'b0, 7'h7f, 4,  8'h00, 8'h40, 2'b11, 2'b01};
    tbl[1] = '{1'b0, 7'h7f, 1,  8'h00, 8'h40, 2'b11, 2'b01};
    tbl[2] = '{1'b1, 7'h4f, 20, 8'h00, 8'h08, 2'b11, 2'b01};
    tbl[3] = '{1'b0, 7'h3f, 4,  8'h01, 8'h08, 2'b11, 2'b00};
    for (int i = 0; i < 8; i++)
      tbl[4+i] = '{1'b1, enc(i), 4, 8'h01, 8'h01 << i, 2'b11, 2'b00};
    tbl[12] = '{1'b1, 7'h06, 3, 8'h01, 8'h80, 2'b01, 2'b00};
    tbl[13] = '{1'b1, 7'h06, 1, 8'h01, 8'h02, 2'b11, 2'b00};
    tbl[14] = '{1'b0, 7'h00, 4, 8'h00, 8'h02, 2'b11, 2'b01};

    for (int v = 0; v < 15; v++) begin
      for (int e = 0; e < tbl[v].edges; e++) step(tbl[v].cath, tbl[v].pat);
      chk($sformatf("vec%0d_num0", v), num0, tbl[v].num0);
      chk($sformatf("vec%0d_num1", v), num1, tbl[v].num1);
      chk($sformatf("vec%0d_locked", v), locked, tbl[v].locked);
      chk($sformatf("vec%0d_invalid", v), invalid, tbl[v].invalid);
    end

    // Reset while digit0 is mid-track.
    step(1'b0, 7'h5b);
    step(1'b0, 7'h5b);
    rst_n = 1'b0;
    #1;
    chk("rst_async_clear", {num0, num1, locked, invalid, update}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_held_clear", {num0, num1, locked, invalid, update}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(i[0], i[0] ? 7'h7d : 7'h3f);
      chk($sformatf("rst_post_%0d", i), {num0, num1, locked, invalid}, 32'h0);
    end

    chk("never_both_updates", both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
